// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: redirect request, IMem address/data and the decode handshake.
interface fetch_queue_if #(
   parameter int unsigned ADDR_SIZE  = 32,
   parameter int unsigned INSTR_SIZE = 32
);
   logic                  redirectValid;
   logic [ADDR_SIZE-1:0]  redirectPC;
   logic [ADDR_SIZE-1:0]  imemAddr;
   logic [INSTR_SIZE-1:0] imemData;
   logic                  instrValid;
   logic                  instrReady;
   logic [INSTR_SIZE-1:0] instrData;
   logic [ADDR_SIZE-1:0]  instrPC;

   modport master (
      input  redirectValid, redirectPC, imemData, instrReady,
      output imemAddr, instrValid, instrData, instrPC
   );

   modport slave (
      output redirectValid, redirectPC, imemData, instrReady,
      input  imemAddr, instrValid, instrData, instrPC
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, addresses IMem and buffers
// {pc, instr} pairs in a small FIFO drained by decode; redirect flushes it.
module fetch_queue #(
   parameter int unsigned          ADDR_SIZE   = 32,
   parameter int unsigned          INSTR_SIZE  = 32,
   parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0,
   parameter int unsigned          QUEUE_DEPTH = 2
) (
   input logic           clk,
   input logic           rstn,
   fetch_queue_if.master bus
);
   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH = CNT_W'(QUEUE_DEPTH);

   logic [ADDR_SIZE-1:0]  fetchPC;
   logic [ADDR_SIZE-1:0]  pcMem    [QUEUE_DEPTH];
   logic [INSTR_SIZE-1:0] instrMem [QUEUE_DEPTH];
   logic [PTR_W-1:0]      rdPtr;
   logic [PTR_W-1:0]      wrPtr;
   logic [CNT_W-1:0]      count;
   logic                  enq;
   logic                  deq;

   // Valid depends only on occupancy and redirect, never on instrReady.
   always_comb begin
      bus.instrValid = !bus.redirectValid && (count != '0);
      deq            = bus.instrValid && bus.instrReady;
      enq            = !bus.redirectValid && ((count < DEPTH) || deq);
   end

   assign bus.imemAddr  = fetchPC;
   assign bus.instrData = instrMem[rdPtr];
   assign bus.instrPC   = pcMem[rdPtr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetchPC <= RESET_PC;
         rdPtr   <= '0;
         wrPtr   <= '0;
         count   <= '0;
         for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            pcMem[i]    <= '0;
            instrMem[i] <= '0;
         end
      end else if (bus.redirectValid) begin
         fetchPC <= bus.redirectPC & ~ADDR_SIZE'(3);
         rdPtr   <= '0;
         wrPtr   <= '0;
         count   <= '0;
      end else begin
         if (deq) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         if (enq) begin
            pcMem[wrPtr]    <= fetchPC;
            instrMem[wrPtr] <= bus.imemData;
            wrPtr           <= wrPtr + PTR_W'(1);
            fetchPC         <= fetchPC + ADDR_SIZE'(4);
         end
         if (enq && !deq) begin
            count <= count + CNT_W'(1);
         end else if (deq && !enq) begin
            count <= count - CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed + randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
   localparam int unsigned DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk;
   logic rstn;
   int   nTests;
   int   nFail;

   logic [31:0] mq [$];
   logic [31:0] mPC;

   fetch_queue_if #(.ADDR_SIZE(32), .INSTR_SIZE(32)) fq_bus ();

   fetch_queue #(
      .ADDR_SIZE(32),
      .INSTR_SIZE(32),
      .RESET_PC(RST_PC),
      .QUEUE_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(fq_bus.master)
   );

   function automatic logic [31:0] imem_word(input logic [31:0] addr);
      return 32'h1000_0000 + (addr >> 2);
   endfunction

   assign fq_bus.imemData = imem_word(fq_bus.imemAddr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      assert (got === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Called in the low clock phase; asserts reset, checks outputs before any edge, releases.
   task automatic do_reset();
      rstn = 1'b0;
      #1;
      check("rst_imemAddr", fq_bus.imemAddr, RST_PC);
      check("rst_instrValid", 32'(fq_bus.instrValid), 32'd0);
      check("rst_instrPC", fq_bus.instrPC, 32'd0);
      check("rst_instrData", fq_bus.instrData, 32'd0);
      mq.delete();
      mPC = RST_PC;
      #1;
      rstn = 1'b1;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic step(input logic redir, input logic [31:0] target, input logic ready);
      logic expValid;
      logic doDeq;
      logic doEnq;
      fq_bus.redirectValid = redir;
      fq_bus.redirectPC    = target;
      fq_bus.instrReady    = ready;
      #1;
      expValid = !redir && (mq.size() != 0);
      check("imemAddr", fq_bus.imemAddr, mPC);
      check("instrValid", 32'(fq_bus.instrValid), 32'(expValid));
      if (expValid) begin
         check("instrPC", fq_bus.instrPC, mq[0]);
         check("instrData", fq_bus.instrData, imem_word(mq[0]));
      end
      if (redir) begin
         mq.delete();
         mPC = {target[31:2], 2'b00};
      end else begin
         doDeq = expValid && ready;
         doEnq = (mq.size() < DEPTH) || doDeq;
         if (doDeq) void'(mq.pop_front());
         if (doEnq) begin
            mq.push_back(mPC);
            mPC = mPC + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] tgt;
      nTests = 0;
      nFail  = 0;
      rstn   = 1'b0;
      fq_bus.redirectValid = 1'b0;
      fq_bus.redirectPC    = '0;
      fq_bus.instrReady    = 1'b0;
      mPC = RST_PC;
      repeat (2) @(negedge clk);

      // Reset and streaming
      do_reset();
      repeat (6) step(1'b0, 32'd0, 1'b1);

      // Backpressure then release
      @(negedge clk);
      do_reset();
      repeat (5) step(1'b0, 32'd0, 1'b0);
      check("bp_frozen_addr", fq_bus.imemAddr, 32'h8);
      repeat (5) step(1'b0, 32'd0, 1'b1);

      // Redirect while full
      do_reset();
      repeat (3) step(1'b0, 32'd0, 1'b0);
      step(1'b1, 32'h0000_0103, 1'b0);
      check("redir_target_addr", fq_bus.imemAddr, 32'h100);
      repeat (4) step(1'b0, 32'd0, 1'b1);

      // Simultaneous enqueue/dequeue at full
      repeat (3) step(1'b0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 1'b1);
      repeat (2) step(1'b0, 32'd0, 1'b0);

      // Address wrap-around
      step(1'b1, 32'hFFFF_FFF8, 1'b1);
      repeat (6) step(1'b0, 32'd0, 1'b1);

      // Async reset mid-run with one entry queued
      do_reset();
      repeat (3) step(1'b0, 32'd0, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
         if (i % 97 == 50) begin
            do_reset();
         end
         step($urandom_range(15) == 0, tgt, $urandom_range(3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage that sits directly upstream of the instruction memory and feeds decode. It owns the fetch PC, drives the IMem word address, captures the combinational IMem read data, and buffers fetched instructions with their PCs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect from branch/jump resolution flushes the FIFO and restarts fetch at a new target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `QUEUE_DEPTH`, 2: FIFO entries; power of two, ≥2.
- `ADDR_SIZE`, 32: PC/address width.
- `INSTR_SIZE`, 32: instruction width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `redirectValid`  in  1  flush request; the FIFO is flushed and fetch restarts at `redirectPC`.
- `redirectPC`  in  ADDR_SIZE  redirect target; bits [1:0] ignored (forced to 0).
- `imemAddr`  out  ADDR_SIZE  byte address to IMem; equals fetch PC.
- `imemData`  in  INSTR_SIZE  IMem read data; combinational, valid in the same cycle as `imemAddr`.
- `instrValid`  out  1  FIFO head holds a valid instruction.
- `instrReady`  in  1  decode accepts the head this cycle.
- `instrData`  out  INSTR_SIZE  head instruction.
- `instrPC`  out  ADDR_SIZE  PC of the head instruction.

## Operation
- State: `fetchPC` register, FIFO storage of {pc, instr} × QUEUE_DEPTH, read/write pointers (log2 depth bits, wrap naturally), occupancy count (log2 depth + 1 bits).
- `imemAddr = fetchPC` at all times; `fetchPC[1:0]` is always 0.
- Dequeue: `deq = instrValid && instrReady`. Advances the read pointer.
- Enqueue: `enq = !redirectValid && (count < QUEUE_DEPTH || deq)`. Writes {fetchPC, imemData} at the write pointer and advances it; `fetchPC <= fetchPC + 4`.
- Count: +1 on enq only, −1 on deq only, unchanged on both or neither.
- Full with no dequeue: no enqueue; `fetchPC` holds, so `imemAddr` is stable (stall).
- Redirect (`redirectValid=1`) has priority over everything. Count and pointers are cleared to 0, `fetchPC <= {redirectPC[31:2], 2'b00}`, no enqueue. `instrValid` is forced 0 combinationally in that cycle, so no dequeue can occur.
- PC arithmetic is modulo 2^ADDR_SIZE: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- `instrData`/`instrPC` come from the head entry. When the FIFO is empty they show stale storage contents (0 after reset). Decode must qualify them with `instrValid`.

## Timing
- Reset (async assert, `rstn=0`): `fetchPC=RESET_PC`, so `imemAddr=RESET_PC`. Count and pointers are 0, so `instrValid=0`. All storage is 0, so `instrData=0` and `instrPC=0`. Release is synchronous to `clk` by the integrator. Fetch begins in the first cycle with `rstn=1`.
- Fetch-to-decode latency: an instruction fetched (enqueued) in cycle k is visible with `instrValid=1` in cycle k+1.
- Redirect penalty: redirect in cycle N → target fetched in N+1 → target instruction at decode in N+2.
- Steady state with `instrReady` held high: one instruction per cycle; count oscillates at most to 1.
- Decode stalled: FIFO fills to QUEUE_DEPTH in QUEUE_DEPTH cycles, then fetch stalls. On the first cycle `instrReady` returns high, enqueue and dequeue happen together (full-with-dequeue is allowed). No bubble.
- `instrValid` must not depend combinationally on `instrReady`. It depends only on count and `redirectValid`.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight instructions are discarded.

## Test plan
- Reset/streaming: `RESET_PC=0`, IMem word i = 32'h1000_0000+i, `instrReady=1`. Expect `instrValid=0` in cycle 0. From cycle 1, (instrPC, instrData) = (0, 1000_0000), (4, 1000_0001), (8, 1000_0002) on consecutive cycles.
- Backpressure: `instrReady=0` for 5 cycles from reset. Expect `imemAddr` to freeze at 0x8 after 2 enqueues (depth 2) and count=2. Then set `instrReady=1`: expect PCs 0, 4, 8, C delivered on consecutive cycles with no bubble or duplicate.
- Redirect with full FIFO: FIFO full (PCs 0, 4), assert `redirectValid` with `redirectPC=32'h0000_0103`. Expect `instrValid=0` that cycle and `imemAddr=0x100` next cycle. Next delivered instrPC is 0x100 two cycles after the redirect; PCs 0 and 4 are never delivered after the redirect.
- Simultaneous enq/deq at full: count=2, `instrReady=1` for one cycle. Expect count stays 2, head advances by one PC, and `imemAddr` advances by 4.
- Wrap-around: redirect to 32'hFFFF_FFF8 with `instrReady=1`. Expect delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset mid-run: pulse `rstn` low between clock edges while count=1. Expect `instrValid=0` and `imemAddr=RESET_PC` immediately, before the next clock edge.
